// File: rtl/led_pwm_duty_monitor.sv
// led_pwm_duty_monitor: eight-channel PWM duty meter with peak channel and valid/ready result
module led_pwm_duty_monitor #(
   parameter int PERIOD      = 600,
   parameter int SYNC_STAGES = 2,
   parameter int DUTY_W      = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [7:0]          pwm_in,
   input  logic                restart,
   output logic [8*DUTY_W-1:0] duty_flat,
   output logic [2:0]          peak_idx,
   output logic [DUTY_W-1:0]   peak_duty,
   output logic                duty_valid,
   input  logic                duty_ready,
   output logic                overrun
);
   logic [7:0]        sync_q [SYNC_STAGES];
   logic [7:0]        s;
   logic [9:0]        wcnt;
   logic [DUTY_W-1:0] acc [8];
   logic [DUTY_W-1:0] nxt [8];
   logic [2:0]        pk_i;
   logic [DUTY_W-1:0] pk_d;
   logic              wend;
   logic              latch;
   assign s     = sync_q[SYNC_STAGES-1];
   assign wend  = wcnt == 10'(PERIOD - 1);
   assign latch = wend && !restart;
   always_comb begin
      pk_i = '0;
      pk_d = '0;
      for (int i = 0; i < 8; i++) begin
         nxt[i] = acc[i] + DUTY_W'(s[i]);
         pk_i   = nxt[i] > pk_d ? 3'(i) : pk_i;
         pk_d   = nxt[i] > pk_d ? nxt[i] : pk_d;
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < SYNC_STAGES; k++) sync_q[k] <= '0;
      end else begin
         sync_q[0] <= pwm_in;
         for (int k = 1; k < SYNC_STAGES; k++) sync_q[k] <= sync_q[k-1];
      end
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         wcnt       <= '0;
         for (int i = 0; i < 8; i++) acc[i] <= '0;
         duty_flat  <= '0;
         peak_idx   <= '0;
         peak_duty  <= '0;
         duty_valid <= 1'b0;
         overrun    <= 1'b0;
      end else begin
         wcnt <= (restart || wend) ? '0 : wcnt + 10'd1;
         for (int i = 0; i < 8; i++) acc[i] <= (restart || wend) ? '0 : nxt[i];
         if (latch) begin
            for (int i = 0; i < 8; i++) duty_flat[i*DUTY_W +: DUTY_W] <= nxt[i];
            peak_idx   <= pk_i;
            peak_duty  <= pk_d;
            duty_valid <= 1'b1;
            overrun    <= overrun | (duty_valid & ~duty_ready);
         end else if (duty_ready) begin
            duty_valid <= 1'b0;
         end
      end
   end
endmodule

// File: doc/led_pwm_duty_monitor.md
Name: led_pwm_duty_monitor

Overview:
- Eight-channel PWM duty-cycle meter. It is the receive side of the LED PWM drive interface: it samples the 8-bit LED PWM bus.
- Over each fixed measurement window it counts the high cycles per channel and presents the result to a consumer through a valid/ready handshake.
- It also reports the brightest channel, which is the flow head in water-flow mode.
- It is used for on-chip loopback self-check of the LED mode drivers and for debug readout.

Parameters:
- PERIOD, 600, measurement window length in clk cycles; legal range 2..1023; matches the LED PWM period.
- SYNC_STAGES, 2, input synchronizer depth; legal range 1..3.
- DUTY_W, 10, width of each duty result; must satisfy 2^DUTY_W > PERIOD.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- pwm_in  in  8  LED PWM bus under measurement; bit i is channel i; may be asynchronous to clk.
- restart  in  1  synchronous pulse; restarts the current window.
- duty_flat  out  8*DUTY_W  latched duty counts; channel i occupies bits [i*DUTY_W +: DUTY_W].
- peak_idx  out  3  index of the channel with the largest latched duty.
- peak_duty  out  DUTY_W  duty value of channel peak_idx.
- duty_valid  out  1  result available.
- duty_ready  in  1  consumer accepts the result.
- overrun  out  1  sticky flag: an unconsumed result was overwritten.

Behaviour:

Reset (rst=1 at a clk edge):
- Synchronizer registers, window counter wcnt and all 8 accumulators go to 0.
- duty_flat, peak_idx, peak_duty, duty_valid and overrun all go to 0.
- Reset mid-window discards the partial window. The next window starts on the first cycle with rst=0.

Synchronizer:
- Each pwm_in bit passes through SYNC_STAGES flops; s[i] is the final stage.
- Measurement latency from pwm_in to s is SYNC_STAGES cycles.
- Sync flops reset to 0, so the first window after reset under-counts a constant-high input by SYNC_STAGES.

Window counter:
- wcnt counts 0..PERIOD-1 and wraps to 0. The cycle where wcnt==PERIOD-1 is the window end (wend).

Accumulators:
- Each cycle, acc[i] <= acc[i] + s[i].
- On wend, acc[i] resets to 0; the sample taken on the wend cycle belongs to the closing window and goes into the latched value.
- acc never exceeds PERIOD; no saturation logic is needed.

Latch:
- On the clk edge ending the wend cycle, duty[i] <= acc[i] + s[i] for all 8 channels.
- peak_idx and peak_duty are computed from those same 8 values in the same edge. Outputs update 1 cycle after the wend sample.
- Peak selection: strictly greatest value; ties resolve to the lowest index; all-zero gives peak_idx=0, peak_duty=0.

Handshake:
- duty_valid rises with the latch and holds until a cycle with duty_valid && duty_ready, then drops on the next edge.
- duty_flat, peak_idx and peak_duty are stable while duty_valid=1 unless overwritten.
- If a new latch occurs while duty_valid=1 and no handshake completes that cycle:
  - outputs are overwritten with the new window's values;
  - duty_valid stays 1;
  - overrun <= 1.
- If a handshake and a new latch coincide in the same cycle: new data latches, duty_valid stays 1, overrun is unchanged.
- overrun clears only on rst.

restart:
- wcnt <= 0 and all acc <= 0; the current window's samples are discarded.
- Latched outputs, duty_valid and overrun are unaffected.
- restart takes priority over wend in the same cycle: no latch occurs.

Test Plan:
1. PERIOD=600, SYNC_STAGES=2, pwm_in=8'hFF held from reset, duty_ready=1:
   - 1st result: all channels 598, peak_idx=0.
   - 2nd result: all channels 600.
   - duty_valid pulses 1 cycle per window; overrun=0.
2. Channel 3 driven high for 40 of every 600 cycles, others 0, window-aligned after the 2nd window:
   - duty[3]=40, others 0, peak_idx=3, peak_duty=40.
3. Channels 2 and 5 both high 300/600, channel 7 high 120/600:
   - peak_idx=2 (tie to lowest index), peak_duty=300, duty[7]=120.
4. duty_ready=0 across two window ends:
   - duty_valid stays 1 and overrun=1 after the 2nd latch; data equals the 2nd window's values.
   - Raising duty_ready for 1 cycle drops duty_valid; overrun stays 1 until rst.
5. restart asserted at wcnt=300 with pwm_in=8'hFF in steady state:
   - next latch occurs 600 cycles after restart with all channels 600.
   - Held outputs are unchanged meanwhile; restart coincident with wend produces no latch.
6. rst asserted at wcnt=450 with duty_valid=1:
   - next cycle all outputs 0; the next result arrives exactly PERIOD cycles after rst deasserts.
